// File: rtl/mandelbrot_pkg.sv
// Shared types and widths for the Mandelbrot pixel sink and its byte FIFO.
//   state_e      : sink FSM states
//   fifo_entry_t : one buffered output byte plus its frame-last flag
package mandelbrot_pkg;

    localparam int unsigned PIX_W = 4;
    localparam int unsigned OUT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_e;

    typedef struct packed {
        logic             last;
        logic [OUT_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/mandelbrot_byte_fifo.sv
// Circular byte FIFO with an explicit occupancy counter.
//   clk, reset : clock, synchronous active-high reset
//   push_i     : write data_i at the tail (never asserted when full)
//   data_i     : byte + last flag to store
//   pop_i      : remove the head entry (ignored when empty)
//   head_o     : head entry, all zeros when empty
//   count_o    : number of stored entries
//   full_o     : count == DEPTH
//   empty_o    : count == 0
module mandelbrot_byte_fifo
    import mandelbrot_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  fifo_entry_t      data_i,
    input  logic             pop_i,
    output fifo_entry_t      head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    fifo_entry_t      mem_q [DEPTH];
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mandelbrot_pixel_sink.sv
// Paces the Mandelbrot core one pixel at a time, packs two 4-bit results per
// byte and streams the bytes out through a small FIFO.
//   clk, reset     : clock, synchronous active-high reset
//   start          : one-cycle pulse, begins a frame when idle
//   core_run       : run pulse to the core
//   core_running   : core busy flag
//   core_ctr       : core iteration count, valid the cycle running falls
//   core_finished  : core frame-complete flag, sampled with the pixel
//   out_data       : earlier pixel in [3:0], later pixel in [7:4]
//   out_last       : byte holds the final pixel of the frame
//   out_valid      : FIFO not empty
//   out_ready      : consumer accepts the byte
//   busy           : FSM not IDLE
//   frame_done     : pulse after the last byte of a frame is popped
module mandelbrot_pixel_sink
    import mandelbrot_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             core_run,
    input  logic             core_running,
    input  logic [PIX_W-1:0] core_ctr,
    input  logic             core_finished,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    state_e           state_q, state_d;
    logic             half_q, half_d;
    logic [PIX_W-1:0] pack_q, pack_d;
    logic             running_q;
    logic             core_run_q, core_run_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;

    logic             pixel_done;
    logic             push;
    logic             pop;
    fifo_entry_t      push_entry;
    fifo_entry_t      head;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_d;
    logic             fifo_full;
    logic             fifo_empty;

    assign pixel_done = running_q & ~core_running;
    assign out_valid  = ~fifo_empty;
    assign pop        = out_valid & out_ready;
    assign out_data   = head.data;
    assign out_last   = head.last;

    // Next-state, packing and registered-output lookahead.
    // core_run is registered, so it is computed from the state and FIFO
    // occupancy of the coming cycle: it is high exactly in ISSUE cycles
    // that have room for another byte.
    always_comb begin
        state_d      = state_q;
        half_d       = half_q;
        pack_d       = pack_q;
        push         = 1'b0;
        push_entry   = '0;
        frame_done_d = pop & head.last;

        case (state_q)
            IDLE: begin
                if (start) state_d = ISSUE;
            end
            ISSUE: begin
                if (core_run_q) state_d = BUSY;
            end
            BUSY: begin
                if (pixel_done) begin
                    if (half_q) begin
                        push            = 1'b1;
                        push_entry.last = core_finished;
                        push_entry.data = {core_ctr, pack_q};
                        half_d          = 1'b0;
                        state_d         = core_finished ? IDLE : ISSUE;
                    end else if (core_finished) begin
                        // Odd pixel count: final byte carries one pixel.
                        push            = 1'b1;
                        push_entry.last = 1'b1;
                        push_entry.data = {{PIX_W{1'b0}}, core_ctr};
                        state_d         = IDLE;
                    end else begin
                        pack_d  = core_ctr;
                        half_d  = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        count_d    = fifo_count + CNT_W'(push) - CNT_W'(pop);
        core_run_d = (state_d == ISSUE) && (count_d < CNT_W'(DEPTH));
        busy_d     = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            half_q       <= 1'b0;
            pack_q       <= '0;
            running_q    <= 1'b0;
            core_run_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            half_q       <= half_d;
            pack_q       <= pack_d;
            running_q    <= core_running;
            core_run_q   <= core_run_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign core_run   = core_run_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    // The ISSUE gate must keep pushes away from a full FIFO.
    assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

    mandelbrot_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_mandelbrot_pixel_sink.sv
// Scoreboard bench for mandelbrot_pixel_sink with a behavioural core model.
module tb_mandelbrot_pixel_sink;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       core_run;
    logic       core_running;
    logic [3:0] core_ctr;
    logic       core_finished;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       frame_done;

    int         total = 0;
    int         bad = 0;
    int         run_cnt = 0;
    int         fd_cnt = 0;
    bit         fd_exp = 1'b0;
    logic [8:0] exp_q [$];
    logic [8:0] e;

    int         npix = 1;
    logic [3:0] base = 4'h0;
    int         pidx;
    int         lat;

    mandelbrot_pixel_sink #(.DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .core_run      (core_run),
        .core_running  (core_running),
        .core_ctr      (core_ctr),
        .core_finished (core_finished),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Core model: pixel value is base + index (mod 16), random latency.
    always @(posedge clk) begin
        if (reset) begin
            core_running  <= 1'b0;
            core_ctr      <= 4'h0;
            core_finished <= 1'b0;
            pidx          <= 0;
            lat           <= 0;
        end else if (core_run && !core_running) begin
            core_running  <= 1'b1;
            core_finished <= 1'b0;
            lat           <= int'($urandom_range(1, 3));
            run_cnt       <= run_cnt + 1;
        end else if (core_running) begin
            if (lat <= 1) begin
                core_running  <= 1'b0;
                core_ctr      <= base + 4'(pidx);
                core_finished <= (pidx == npix - 1);
                pidx          <= (pidx == npix - 1) ? 0 : pidx + 1;
            end else begin
                lat <= lat - 1;
            end
        end
    end

    // Output monitor: pops the scoreboard on every accepted byte.
    always @(negedge clk) begin
        chk("frame_done", 32'(frame_done), 32'(fd_exp));
        if (frame_done) fd_cnt++;
        fd_exp = 1'b0;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_byte", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("byte", {23'b0, out_last, out_data}, {23'b0, e});
                fd_exp = e[8];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int n, input logic [3:0] b);
        logic [3:0] v0;
        logic [3:0] v1;
        npix = n;
        base = b;
        for (int i = 0; i < n; i += 2) begin
            v0 = b + 4'(i);
            v1 = b + 4'(i + 1);
            if (i + 1 < n) exp_q.push_back({(i + 2 == n), v1, v0});
            else           exp_q.push_back({1'b1, 4'h0, v0});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc, input bit rnd_ready);
        int n = 0;
        while ((busy || out_valid || exp_q.size() != 0) && n < max_cyc) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk(tag, 32'(n >= max_cyc), 32'd0);
        out_ready = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        int r0;
        int f0;
        int n;

        repeat (3) tick();
        chk("rst_core_run", 32'(core_run), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        reset = 1'b0;
        tick();

        // Even frame, consumer always ready.
        out_ready = 1'b1;
        r0 = run_cnt; f0 = fd_cnt;
        start_frame(8, 4'h0);
        wait_idle("t1_timeout", 300, 1'b0);
        chk("t1_runs", 32'(run_cnt - r0), 32'd8);
        chk("t1_frames", 32'(fd_cnt - f0), 32'd1);

        // Same frame with consumer stalled: fills the FIFO exactly.
        out_ready = 1'b0;
        r0 = run_cnt; f0 = fd_cnt;
        start_frame(8, 4'h0);
        repeat (120) tick();
        chk("t2_runs", 32'(run_cnt - r0), 32'd8);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_head", 32'(out_data), 32'h10);
        out_ready = 1'b1;
        wait_idle("t2_timeout", 100, 1'b0);
        chk("t2_frames", 32'(fd_cnt - f0), 32'd1);

        // Long frame stalls with the FIFO full, then drains through wrap.
        out_ready = 1'b0;
        r0 = run_cnt; f0 = fd_cnt;
        start_frame(20, 4'h0);
        repeat (150) tick();
        chk("t3_stall_runs", 32'(run_cnt - r0), 32'd8);
        chk("t3_stall_busy", 32'(busy), 32'd1);
        chk("t3_stall_run", 32'(core_run), 32'd0);
        wait_idle("t3_timeout", 1500, 1'b1);
        chk("t3_runs", 32'(run_cnt - r0), 32'd20);
        chk("t3_frames", 32'(fd_cnt - f0), 32'd1);

        // Odd frame: 5,6,7 -> 0x65 then 0x07 with last.
        out_ready = 1'b1;
        r0 = run_cnt; f0 = fd_cnt;
        start_frame(3, 4'h5);
        wait_idle("t4_timeout", 200, 1'b0);
        chk("t4_runs", 32'(run_cnt - r0), 32'd3);
        chk("t4_frames", 32'(fd_cnt - f0), 32'd1);

        // Reset while BUSY with two bytes queued.
        out_ready = 1'b0;
        r0 = run_cnt;
        start_frame(20, 4'h0);
        n = 0;
        while (run_cnt - r0 < 5 && n < 200) begin
            tick();
            n++;
        end
        chk("t5_wait_timeout", 32'(n >= 200), 32'd0);
        chk("t5_pre_busy", 32'(busy), 32'd1);
        chk("t5_pre_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        tick();
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_core_run", 32'(core_run), 32'd0);
        exp_q.delete();
        reset = 1'b0;
        tick();
        out_ready = 1'b1;
        r0 = run_cnt; f0 = fd_cnt;
        start_frame(4, 4'h0);
        wait_idle("t5_timeout", 200, 1'b0);
        chk("t5_runs", 32'(run_cnt - r0), 32'd4);
        chk("t5_frames", 32'(fd_cnt - f0), 32'd1);

        // Extra start while busy must be ignored.
        r0 = run_cnt; f0 = fd_cnt;
        start_frame(6, 4'h3);
        repeat (2) tick();
        chk("t6_busy_mid", 32'(busy), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("t6_timeout", 300, 1'b0);
        repeat (20) tick();
        chk("t6_runs", 32'(run_cnt - r0), 32'd6);
        chk("t6_frames", 32'(fd_cnt - f0), 32'd1);
        chk("t6_busy_end", 32'(busy), 32'd0);
        chk("t6_valid_end", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
